// File: rtl/mem_arbiter_pkg.sv
// Shared types and bus widths for the external memory arbiter and its helpers.
package mem_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr_en;
        logic [1:0]        bytesel;
        logic              access;
    } mem_req_t;

    // Value driven onto the bus whenever nobody holds the grant.
    function automatic mem_req_t idle_req();
        return '0;
    endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of data grants won while an instruction fetch was waiting.
module mem_arb_streak #(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic instr_access,
    input  logic enter_instr,
    input  logic enter_data,
    output logic at_max
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    logic [3:0] streak_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_reg <= '0;
        end else if (idle && (!instr_access || enter_instr)) begin
            streak_reg <= '0;
        end else if (idle && enter_data && (streak_reg != STREAK_MAX)) begin
            // Reaching here implies instr is still waiting behind this data grant.
            streak_reg <= streak_reg + 4'd1;
        end
    end

    assign at_max = (streak_reg == STREAK_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 16-bit external memory bus between instruction prefetch and load/store,
// data first but with bounded starvation of instruction fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instr_m_addr,
    input  logic              instr_m_access,
    output logic              instr_m_ack,
    output logic [DATA_W-1:0] instr_m_data_in,
    input  logic [ADDR_W-1:0] data_m_addr,
    input  logic [DATA_W-1:0] data_m_data_out,
    input  logic              data_m_access,
    input  logic              data_m_wr_en,
    input  logic [1:0]        data_m_bytesel,
    output logic              data_m_ack,
    output logic [DATA_W-1:0] data_m_data_in,
    output logic [ADDR_W-1:0] q_m_addr,
    output logic [DATA_W-1:0] q_m_data_out,
    output logic              q_m_access,
    output logic              q_m_wr_en,
    output logic [1:0]        q_m_bytesel,
    input  logic              q_m_ack,
    input  logic [DATA_W-1:0] q_m_data_in
);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       streak_at_max;
    mem_req_t   instr_req;
    mem_req_t   data_req;
    mem_req_t   bus_req;

    mem_arb_streak #(
        .DATA_STREAK_MAX(DATA_STREAK_MAX)
    ) u_streak (
        .clk         (clk),
        .reset       (reset),
        .idle        (state_reg == IDLE),
        .instr_access(instr_m_access),
        .enter_instr (state_reg == IDLE && state_next == GRANT_INSTR),
        .enter_data  (state_reg == IDLE && state_next == GRANT_DATA),
        .at_max      (streak_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (data_m_access && !(instr_m_access && streak_at_max)) begin
                    state_next = GRANT_DATA;
                end else if (instr_m_access) begin
                    state_next = GRANT_INSTR;
                end
            end
            // A grant ends only on completion or on the holder withdrawing.
            GRANT_INSTR: if (q_m_ack || !instr_m_access) state_next = IDLE;
            GRANT_DATA:  if (q_m_ack || !data_m_access) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    assign instr_req = '{
        addr:    instr_m_addr,
        data:    '0,
        wr_en:   1'b0,
        bytesel: 2'b11,
        access:  instr_m_access
    };

    assign data_req = '{
        addr:    data_m_addr,
        data:    data_m_data_out,
        wr_en:   data_m_wr_en,
        bytesel: data_m_bytesel,
        access:  data_m_access
    };

    always_comb begin
        bus_req     = idle_req();
        instr_m_ack = 1'b0;
        data_m_ack  = 1'b0;
        case (state_reg)
            GRANT_INSTR: begin
                bus_req     = instr_req;
                instr_m_ack = q_m_ack;
            end
            GRANT_DATA: begin
                bus_req    = data_req;
                data_m_ack = q_m_ack;
            end
            default: ;
        endcase
    end

    assign q_m_addr     = bus_req.addr;
    assign q_m_data_out = bus_req.data;
    assign q_m_wr_en    = bus_req.wr_en;
    assign q_m_bytesel  = bus_req.bytesel;
    assign q_m_access   = bus_req.access;

    // Read data is shared; each consumer qualifies it with its own ack.
    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 16-bit external memory bus between the instruction prefetcher and the data load/store unit.
- Each requester holds its access until it receives an ack.
- Data has priority, with a bounded-starvation guarantee for instruction fetch.
- Sits between the requesters (prefetch, load/store) and the top-level m_* bus pins.

Parameters:
- DATA_STREAK_MAX, 4, consecutive data grants allowed while instr is waiting before instr is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_m_addr  in  19  instruction word address [19:1]
- instr_m_access  in  1  instruction request; held until ack
- instr_m_ack  out  1  completion strobe to prefetcher
- instr_m_data_in  out  16  read data to prefetcher
- data_m_addr  in  19  data word address [19:1]
- data_m_data_out  in  16  write data from load/store
- data_m_access  in  1  data request; held until ack
- data_m_wr_en  in  1  1 = write, 0 = read
- data_m_bytesel  in  2  byte lane enables, [0] low byte
- data_m_ack  out  1  completion strobe to load/store
- data_m_data_in  out  16  read data to load/store
- q_m_addr  out  19  bus address
- q_m_data_out  out  16  bus write data
- q_m_access  out  1  bus request
- q_m_wr_en  out  1  bus write enable
- q_m_bytesel  out  2  bus byte enables
- q_m_ack  in  1  bus completion strobe (single cycle)
- q_m_data_in  in  16  bus read data

Behaviour:
- State machine: IDLE, GRANT_INSTR, GRANT_DATA. Grant is registered.
- IDLE arbitration at each clk edge:
  - Only data_m_access set → GRANT_DATA.
  - Only instr_m_access set → GRANT_INSTR.
  - Both set → GRANT_INSTR if streak == DATA_STREAK_MAX, else GRANT_DATA.
  - Neither set → stay in IDLE.
- Streak counter (4 bits):
  - Increments on entry to GRANT_DATA while instr_m_access=1.
  - Clears on entry to GRANT_INSTR, and on any IDLE cycle with instr_m_access=0.
  - Saturates at DATA_STREAK_MAX.
- Latency: request asserted in cycle N from IDLE → q_m_access high in cycle N+1.
- Bus muxing (combinational from the grant state):
  - GRANT_DATA: q_m_addr/wr_en/bytesel/data_out follow the data_* inputs.
  - GRANT_INSTR: q_m_addr=instr_m_addr, q_m_wr_en=0, q_m_bytesel=2'b11, q_m_data_out=0.
  - IDLE: all q_* outputs are 0.
- q_m_access = (granted requester's access) AND grant. If the requester drops access before ack, q_m_access drops in the same cycle and the grant holds until ack or until the requester drops access while in grant. In the latter case return to IDLE at the next edge.
- Ack routing: q_m_ack is steered combinationally to the granted requester only. The non-granted ack is always 0. q_m_ack in IDLE is ignored.
- Read data: q_m_data_in is broadcast to both *_m_data_in unregistered. Consumers must qualify it with their ack.
- Release: on q_m_ack, return to IDLE at that edge. The following cycle is IDLE (one mandatory turnaround cycle) and arbitrates again.
  - The just-served requester's access is still high in the ack cycle but is ignored, because arbitration only happens in IDLE.
  - Back-to-back requests from one requester give one bus access every 2 cycles plus the memory latency.
- No preemption: a grant is never revoked before ack or withdrawal.
- Reset (asynchronous, any time, including mid-access):
  - State=IDLE, streak=0.
  - q_m_access=0, instr_m_ack=0, data_m_ack=0 immediately.
  - q_m_addr/data_out/wr_en/bytesel=0.
- A q_m_ack arriving in the first cycle after reset is ignored.

Decomposition:
- Shared package (e.g. mem_pkg):
  - typedef enum arb_state_t {IDLE, GRANT_INSTR, GRANT_DATA}.
  - Bus-width constants: ADDR_W=19, DATA_W=16.
  - Struct mem_req_t {addr, data, wr_en, bytesel, access}.
- One natural sub-module: mem_arb_streak, the saturating starvation counter with its clear/increment rules.
- The mux and FSM stay in the top-level module.

Test Plan:
- Single data write addr=19'h12345, data=16'hBEEF, bytesel=2'b01, ack 3 cycles later → q_m_access high from cycle N+1, q_m_wr_en=1, data_m_ack pulses once, instr_m_ack stays 0, IDLE for one cycle after ack.
- Simultaneous requests from IDLE (streak=0) → data granted first. After data ack + turnaround, instr granted with q_m_bytesel=2'b11. instr_m_data_in matches q_m_data_in=16'hA5A5 in the instr ack cycle.
- Instr held high while data re-requests continuously, DATA_STREAK_MAX=4 → exactly 4 data grants, then instr granted, then streak=0 and data resumes.
- Requester withdraws access before ack → q_m_access drops the same cycle, FSM returns to IDLE at the next edge, and no ack is routed.
- Assert reset mid-access (GRANT_DATA, before ack) → q_m_access and both acks go 0 asynchronously. After release, a stray q_m_ack produces no requester ack, and a new instr request is granted normally.
- q_m_ack while IDLE with no requests → no ack outputs and no state change.
